// File: rtl/cdc_fifo_write_arbiter_if.sv
// Bundle between N write requesters and the write side of a cdc_fifo.
// master: the arbiter; slave: requesters plus the fifo write port.
interface cdc_fifo_write_arbiter_if #(
    parameter int NUM_REQUESTERS = 4,
    parameter int DATA_WIDTH     = 8
);
    localparam int OW = $clog2(NUM_REQUESTERS);

    logic [NUM_REQUESTERS-1:0]            request;
    logic [NUM_REQUESTERS*DATA_WIDTH-1:0] request_data;
    logic [NUM_REQUESTERS-1:0]            request_last;
    logic [NUM_REQUESTERS-1:0]            grant;
    logic [DATA_WIDTH-1:0]                fifo_write_data;
    logic                                 fifo_write_increment;
    logic                                 fifo_full;
    logic [OW-1:0]                        owner;
    logic                                 busy;

    modport master (
        input  request, request_data, request_last, fifo_full,
        output grant, fifo_write_data, fifo_write_increment, owner, busy
    );

    modport slave (
        output request, request_data, request_last, fifo_full,
        input  grant, fifo_write_data, fifo_write_increment, owner, busy
    );
endinterface

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin burst arbiter feeding one cdc_fifo write port.
// One bubble cycle per arbitration; owner keeps the port until last, MAX_BURST words, or withdrawal.
module cdc_fifo_write_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_BURST      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    cdc_fifo_write_arbiter_if.master bus
);
    localparam int OW = $clog2(NUM_REQUESTERS);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
    localparam logic [OW-1:0] TOP_IDX  = OW'(NUM_REQUESTERS - 1);

    typedef enum logic {IDLE, BURST} state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] rr_q, rr_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          pick_vld;
    logic [OW-1:0] pick_idx;
    logic [OW-1:0] cand;
    logic          own_req, own_last, accept;
    logic [OW-1:0] nxt_rr;

    // Scan offsets from far to near so the candidate closest to rr_q wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
            if (int'(rr_q) + k >= NUM_REQUESTERS)
                cand = OW'(int'(rr_q) + k - NUM_REQUESTERS);
            else
                cand = OW'(int'(rr_q) + k);
            if (bus.request[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign own_req  = bus.request[owner_q];
    assign own_last = bus.request_last[owner_q];
    assign accept   = (state_q == BURST) && own_req && !bus.fifo_full;
    assign nxt_rr   = (owner_q == TOP_IDX) ? '0 : owner_q + OW'(1);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                // Withdrawal wins over a full fifo: nothing to wait for.
                if (!own_req) begin
                    state_d = IDLE;
                    rr_d    = nxt_rr;
                end else if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (own_last || cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        rr_d    = nxt_rr;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_grant
        assign bus.grant[i] = accept && (owner_q == OW'(i));
    end

    assign bus.busy                 = (state_q == BURST);
    assign bus.owner                = owner_q;
    assign bus.fifo_write_increment = accept;
    assign bus.fifo_write_data      = accept ? bus.request_data[owner_q*DATA_WIDTH +: DATA_WIDTH]
                                             : '0;
endmodule
